ffe_tap_mac_ctrl: RTL

//  Read-side controller for the FFE sample register file. Runs once per new sample.

---
 rtl/ffe_tap_mac_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/ffe_tap_mac_ctrl.sv
// ffe_tap_mac_ctrl
//   Read-side controller for the FFE sample register file. For each new sample it
//   reads taps 0..DEPTH-1, multiplies each tap by a programmable signed coefficient,
//   accumulates at full precision, rounds half up, saturates to the output width,
//   then pulses shift_en to age the sample history.
// Ports
//   ffe_clk, rst          clock; asynchronous active-low reset
//   sample_valid          new sample present in tap 0 (1-cycle pulse)
//   rd_en/rd_addr/rd_data register-file read port (rd_data combinational from rd_addr)
//   coef_wr_en/addr/data  coefficient write port (accepted only while idle)
//   shift_en              register-file history shift, 1-cycle pulse
//   y_out/y_valid         filtered output (held) and its update pulse
//   busy                  high while a sample is being processed
//   overrun               sample dropped because busy (1-cycle pulse)
//   coef_wr_ignored       coefficient write dropped because busy (1-cycle pulse)
module ffe_tap_mac_ctrl #(
  parameter int IN_OUT_BUS_WIDTH = 12,
  parameter int DEPTH            = 4,
  parameter int ADDR_SIZE        = $clog2(DEPTH),
  parameter int COEF_WIDTH       = 12,
  parameter int COEF_FRAC        = 10,
  parameter int ACC_WIDTH        = IN_OUT_BUS_WIDTH + COEF_WIDTH + ADDR_SIZE
) (
  input  logic                               ffe_clk,
  input  logic                               rst,
  input  logic                               sample_valid,
  input  logic signed [IN_OUT_BUS_WIDTH-1:0] rd_data,
  input  logic                               coef_wr_en,
  input  logic        [ADDR_SIZE-1:0]        coef_addr,
  input  logic signed [COEF_WIDTH-1:0]       coef_wr_data,
  output logic                               rd_en,
  output logic        [ADDR_SIZE-1:0]        rd_addr,
  output logic                               shift_en,
  output logic signed [IN_OUT_BUS_WIDTH-1:0] y_out,
  output logic                               y_valid,
  output logic                               busy,
  output logic                               overrun,
  output logic                               coef_wr_ignored
);

  localparam int PW = IN_OUT_BUS_WIDTH + COEF_WIDTH;
  localparam int RW = ACC_WIDTH + 1 - COEF_FRAC;
  localparam logic signed [RW-1:0]      Y_MAX = RW'((2 ** (IN_OUT_BUS_WIDTH - 1)) - 1);
  localparam logic signed [RW-1:0]      Y_MIN = ~Y_MAX;
  localparam logic signed [ACC_WIDTH:0] HALF  = (ACC_WIDTH + 1)'(2 ** (COEF_FRAC - 1));
  localparam logic        [ADDR_SIZE-1:0] LAST_TAP = ADDR_SIZE'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, MAC, FINISH} state_t;

  state_t state, state_nxt;

  logic        [ADDR_SIZE-1:0]        k;
  logic signed [ACC_WIDTH-1:0]        acc;
  logic signed [COEF_WIDTH-1:0]       coef [DEPTH];
  logic signed [PW-1:0]               prod;
  logic signed [ACC_WIDTH-1:0]        prod_ext;
  logic signed [ACC_WIDTH:0]          acc_rnd;
  logic signed [RW-1:0]               r;
  logic signed [IN_OUT_BUS_WIDTH-1:0] y_sat;

  always_ff @(posedge ffe_clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    rd_addr   = '0;
    shift_en  = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (sample_valid) state_nxt = MAC;
      end
      MAC: begin
        busy    = 1'b1;
        rd_en   = 1'b1;
        rd_addr = k;
        if (k == LAST_TAP) state_nxt = FINISH;
      end
      FINISH: begin
        busy      = 1'b1;
        shift_en  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Full-precision product, then round half up by adding 0.5 LSB and keeping the
  // integer bits (taking the upper slice is an arithmetic shift), then clamp.
  always_comb begin
    prod     = PW'(rd_data) * PW'(coef[k]);
    prod_ext = {{(ACC_WIDTH - PW){prod[PW-1]}}, prod};
    acc_rnd  = {acc[ACC_WIDTH-1], acc} + HALF;
    r        = acc_rnd[ACC_WIDTH:COEF_FRAC];
    if (r > Y_MAX)      y_sat = {1'b0, {(IN_OUT_BUS_WIDTH - 1){1'b1}}};
    else if (r < Y_MIN) y_sat = {1'b1, {(IN_OUT_BUS_WIDTH - 1){1'b0}}};
    else                y_sat = r[IN_OUT_BUS_WIDTH-1:0];
  end

  always_ff @(posedge ffe_clk or negedge rst) begin
    if (!rst) begin
      k               <= '0;
      acc             <= '0;
      y_out           <= '0;
      y_valid         <= 1'b0;
      overrun         <= 1'b0;
      coef_wr_ignored <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) coef[i] <= '0;
    end else begin
      y_valid         <= 1'b0;
      overrun         <= sample_valid && (state != IDLE);
      coef_wr_ignored <= coef_wr_en && (state != IDLE);
      // A write in IDLE lands before the first MAC edge, so a simultaneous sample
      // already sees the new coefficient.
      if (state == IDLE && coef_wr_en) coef[coef_addr] <= coef_wr_data;
      case (state)
        IDLE: begin
          if (sample_valid) begin
            acc <= '0;
            k   <= '0;
          end
        end
        MAC: begin
          acc <= acc + prod_ext;
          k   <= k + ADDR_SIZE'(1);
        end
        FINISH: begin
          y_out   <= y_sat;
          y_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
